// File: rtl/imem_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_controller
// Description : Fetch sequencer for a combinational instruction memory.
//               Owns the PC, presents it as mem_adress, and registers each
//               returned word into a one-entry slot handed to decode with a
//               valid/ready handshake. Handles redirects, a halt instruction
//               and illegal redirect targets.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   1   rising-edge clock
//   reset           in   1   synchronous, active-high
//   start           in   1   leave IDLE and begin fetching
//   mem_adress      out  32  byte address to instruction memory (= pc)
//   mechine_code    in   32  word returned combinationally for mem_adress
//   instr_valid     out  1   output slot holds an instruction
//   instr_ready     in   1   decode accepts the slot this cycle
//   instr_out       out  32  captured instruction
//   pc_out          out  32  byte address instr_out came from
//   redirect_valid  in   1   branch/jump taken: flush and refetch
//   redirect_pc     in   32  redirect target byte address
//   halted          out  1   controller is in HALT
//   fault           out  1   controller is in FAULT (sticky until reset)
//   fetch_count     out  32  number of valid&&ready handshakes (wraps)
// ============================================================================
module imem_fetch_controller #(
    parameter int unsigned IMEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'h0000_0073
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] mem_adress,
    input  logic [31:0] mechine_code,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    // Byte size of the memory; IMEM_DEPTH is a power of two so the
    // sequential wrap is a simple mask.
    localparam logic [31:0] c_PC_LIMIT = 32'(IMEM_DEPTH * 4);
    localparam logic [31:0] c_PC_MASK  = c_PC_LIMIT - 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_halted;
    logic        r_fault;
    logic [31:0] r_count;

    logic        w_capture;
    logic        w_flush;
    logic        w_slot_free;
    logic        w_bad_target;
    logic        w_handshake;

    assign w_handshake  = r_valid && instr_ready;
    assign w_slot_free  = !r_valid || instr_ready;
    assign w_bad_target = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= c_PC_LIMIT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, next pc and slot control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_flush     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_HALT: begin
                // A redirect outranks any capture; the slot is emptied even
                // if decode is taking it this cycle (that handshake still counts).
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    if (w_bad_target) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_pc_nxt    = redirect_pc;
                        w_state_nxt = ST_RUN;
                    end
                end else if ((r_state == ST_RUN) && w_slot_free) begin
                    w_capture = 1'b1;
                    w_pc_nxt  = (r_pc + 32'd4) & c_PC_MASK;
                    // The halt word itself is delivered; only later fetches stop.
                    if (mechine_code == HALT_WORD) begin
                        w_state_nxt = ST_HALT;
                    end
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pc, output slot, status flags, handshake counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_instr  <= 32'd0;
            r_pc_out <= 32'd0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
            r_count  <= 32'd0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_halted <= (w_state_nxt == ST_HALT);
            r_fault  <= (w_state_nxt == ST_FAULT);

            if (w_handshake) begin
                r_count <= r_count + 32'd1;
            end

            if (w_capture) begin
                r_instr  <= mechine_code;
                r_pc_out <= r_pc;
                r_valid  <= 1'b1;
            end else if (w_flush || instr_ready) begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign mem_adress  = r_pc;
    assign instr_valid = r_valid;
    assign instr_out   = r_instr;
    assign pc_out      = r_pc_out;
    assign halted      = r_halted;
    assign fault       = r_fault;
    assign fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_controller
// Description : Self-checking bench for imem_fetch_controller. A memory model
//               answers mem_adress combinationally; expected deliveries are
//               queued as an instruction stream and a monitor pops/compares
//               on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_controller;

    localparam logic [31:0] c_HALT = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] mem_adress;
    logic [31:0] mechine_code;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    logic [31:0] mem [0:31];
    assign mechine_code = mem[mem_adress[6:2]];

    imem_fetch_controller #(
        .IMEM_DEPTH (32),
        .RESET_PC   (32'h0000_0000),
        .HALT_WORD  (c_HALT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mem_adress     (mem_adress),
        .mechine_code   (mechine_code),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } item_t;

    item_t q[$];
    int    n_cmp     = 0;
    int    n_err     = 0;
    int    exp_count = 0;
    int    n_deliv   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural fetch stream starting at t: sequential words (wrapping
    // at 128 bytes) up to and including the first halt word.
    function automatic void load_stream(input logic [31:0] t);
        logic [31:0] p;
        q.delete();
        p = t;
        for (int i = 0; i < 256; i++) begin
            q.push_back({p, mem[p[6:2]]});
            if (mem[p[6:2]] == c_HALT) break;
            p = (p + 32'd4) % 32'd128;
        end
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake seen just before the edge is a delivery at that edge.
    always @(negedge clk) begin
        item_t it;
        if (!reset && instr_valid && instr_ready) begin
            check("fetch_count", fetch_count, exp_count);
            exp_count++;
            n_deliv++;
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_delivery: got pc_out %h, expected no delivery", pc_out);
            end else begin
                it = q.pop_front();
                check("pc_out", pc_out, it.pc);
                check("instr_out", instr_out, it.word);
                if (it.word == c_HALT) check("halted_on_halt_word", {31'd0, halted}, 32'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        reset          = 1'b1;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        step(2);
        reset     = 1'b0;
        exp_count = 0;
        q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
        check({tag, "_instr"},   instr_out, 32'd0);
        check({tag, "_pc_out"},  pc_out, 32'd0);
        check({tag, "_count"},   fetch_count, 32'd0);
        check({tag, "_halted"},  {31'd0, halted}, 32'd0);
        check({tag, "_fault"},   {31'd0, fault}, 32'd0);
        check({tag, "_adress"},  mem_adress, 32'd0);
    endtask

    initial begin
        logic [31:0] pc_before;
        logic [31:0] bad;
        logic [31:0] tgt;
        bit          redir;

        for (int k = 0; k < 32; k++) mem[k] = 32'h1000_0000 + 32'(k);
        mem[6]      = c_HALT;
        instr_ready = 1'b1;

        // Reset values and startup latency
        do_reset();
        check_reset_outputs("reset");
        start = 1'b1;
        load_stream(32'd0);
        step(1);
        check("start_latency_valid", {31'd0, instr_valid}, 32'd0);
        step(1);
        check("first_valid", {31'd0, instr_valid}, 32'd1);
        check("first_pc_out", pc_out, 32'd0);
        start = 1'b0;
        step(2);

        // Back-pressure while slot holds pc 8
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("stall_pc_out", pc_out, 32'd8);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        instr_ready = 1'b1;
        step(1);
        check("after_stall_pc_out", pc_out, 32'd12);

        // Redirect to 4 while slot holds 12; run through the halt word at 24
        redirect_valid = 1'b1;
        redirect_pc    = 32'd4;
        step(1);
        redirect_valid = 1'b0;
        load_stream(32'd4);
        check("redirect_flush_valid", {31'd0, instr_valid}, 32'd0);
        step(1);
        check("redirect_first_valid", {31'd0, instr_valid}, 32'd1);
        check("redirect_first_pc", pc_out, 32'd4);
        step(6);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        check("halt_flag", {31'd0, halted}, 32'd1);
        step(3);
        check("halt_stays_empty", {31'd0, instr_valid}, 32'd0);
        check("halt_stream_drained", 32'(q.size()), 32'd0);

        // Redirect out of HALT
        redirect_valid = 1'b1;
        redirect_pc    = 32'd4;
        step(1);
        redirect_valid = 1'b0;
        load_stream(32'd4);
        check("unhalt_flag", {31'd0, halted}, 32'd0);
        step(1);
        check("unhalt_pc_out", pc_out, 32'd4);
        step(8);

        // Sequential wrap from 124 to 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'd100;
        step(1);
        redirect_valid = 1'b0;
        load_stream(32'd100);
        step(1);
        check("wrap_start_pc", pc_out, 32'd100);
        step(7);
        check("wrap_pc_out", pc_out, 32'd0);
        check("wrap_no_fault", {31'd0, fault}, 32'd0);

        // Reset mid-stream
        reset = 1'b1;
        step(1);
        check_reset_outputs("midreset");
        reset     = 1'b0;
        exp_count = 0;
        q.delete();

        // Bad redirect targets: misaligned, then out of range
        for (int k = 0; k < 2; k++) begin
            bad = (k == 0) ? 32'h6 : 32'h80;
            do_reset();
            start = 1'b1;
            load_stream(32'd0);
            step(3);
            start     = 1'b0;
            pc_before = mem_adress;
            redirect_valid = 1'b1;
            redirect_pc    = bad;
            step(1);
            redirect_valid = 1'b0;
            q.delete();
            check("bad_fault", {31'd0, fault}, 32'd1);
            check("bad_valid", {31'd0, instr_valid}, 32'd0);
            check("bad_pc_held", mem_adress, pc_before);
            start          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = 32'd8;
            step(3);
            start          = 1'b0;
            redirect_valid = 1'b0;
            check("fault_sticky", {31'd0, fault}, 32'd1);
            check("fault_no_valid", {31'd0, instr_valid}, 32'd0);
            check("fault_pc_held", mem_adress, pc_before);
            check("fault_not_halted", {31'd0, halted}, 32'd0);
            reset = 1'b1;
            step(1);
            reset = 1'b0;
            exp_count = 0;
            check("fault_cleared", {31'd0, fault}, 32'd0);
        end

        // Randomized run: random memory with a few halt words, random
        // back-pressure and random legal redirects
        for (int k = 0; k < 32; k++) mem[k] = $urandom;
        for (int k = 0; k < 3; k++) mem[$urandom_range(31, 0)] = c_HALT;
        do_reset();
        n_deliv = 0;
        start   = 1'b1;
        load_stream(32'd0);
        for (int c = 0; c < 1500; c++) begin
            instr_ready = ($urandom_range(3, 0) != 0);
            redir       = ($urandom_range(11, 0) == 0);
            tgt         = 32'($urandom_range(31, 0)) * 32'd4;
            redirect_valid = redir;
            redirect_pc    = tgt;
            step(1);
            redirect_valid = 1'b0;
            if (redir) load_stream(tgt);
        end
        instr_ready = 1'b1;
        step(40);
        check("random_stream_drained", 32'(q.size()), 32'd0);
        check("random_progress", {31'd0, (n_deliv > 200)}, 32'd1);
        check("random_no_fault", {31'd0, fault}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
